uart_rx_oversampled: RTL

//   Standalone UART receiver: the far end of the serial link driven by the

---
 rtl/uart_rx_oversampled_if.sv | 24 ++
 rtl/uart_rx_oversampled.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled_if.sv
// UART receiver bus: serial line in, received byte and status strobes out.
// Ports: rx (line), rxout, rxdone, frame_err, parity_err, busy.
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] rxout;
    logic                 rxdone;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    // master: the side that drives the serial line and watches results
    modport master (
        output rx,
        input  rxout, rxdone, frame_err, parity_err, busy
    );

    // slave: the receiver itself
    modport slave (
        input  rx,
        output rxout, rxdone, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), mid-bit sampling.
// Ports: clk, rst_n (async, active low), bus (slave: rx in; rxout/rxdone/frame_err/parity_err/busy out).
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_oversampled_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [BW-1:0] LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ONE = BW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HI
    } state_e;

    state_e               state_q;
    logic                 s1_q;
    logic                 srx_q;
    logic [CW-1:0]        clkcnt_q;
    logic [BW-1:0]        bitcnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rxout_q;
    logic                 rxdone_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
`endif

    // Two-flop synchroniser; idle-high reset so no false start after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b1;
            srx_q <= 1'b1;
        end else begin
            s1_q  <= bus.rx;
            srx_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            clkcnt_q <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            rxout_q  <= '0;
            rxdone_q <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            rxdone_q <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!srx_q) begin
                        state_q  <= START;
                        clkcnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    // Recheck the line half a bit in; a high here was a glitch
                    if (clkcnt_q == HALF) begin
                        clkcnt_q <= '0;
                        bitcnt_q <= '0;
                        if (!srx_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clkcnt_q <= clkcnt_q + C_ONE;
                    end
                end
                DATA: begin
                    if (clkcnt_q == FULL) begin
                        clkcnt_q <= '0;
                        shift_q  <= {srx_q, shift_q[DATA_BITS-1:1]};
                        bitcnt_q <= bitcnt_q + B_ONE;
                        if (bitcnt_q == LAST) begin
                            bitcnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q  <= PARITY;
`else
                            state_q  <= STOP;
`endif
                        end
                    end else begin
                        clkcnt_q <= clkcnt_q + C_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clkcnt_q == FULL) begin
                        clkcnt_q <= '0;
                        par_q    <= srx_q;
                        state_q  <= STOP;
                    end else begin
                        clkcnt_q <= clkcnt_q + C_ONE;
                    end
                end
`endif
                STOP: begin
                    if (clkcnt_q == FULL) begin
                        clkcnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data plus parity bit XOR to zero
                        perr_q   <= ^{shift_q, par_q};
`endif
                        if (srx_q) begin
                            rxout_q  <= shift_q;
                            rxdone_q <= 1'b1;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HI;
                        end
                    end else begin
                        clkcnt_q <= clkcnt_q + C_ONE;
                    end
                end
                WAIT_HI: begin
                    // Line is held in break; wait for it to return high
                    if (srx_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rxout      = rxout_q;
    assign bus.rxdone     = rxdone_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.busy       = busy_q;
endmodule
